// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding, event record and default timing constants for the parking gate
package parking_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_OPEN,
      ST_CLOSE,
      ST_HOLD
   } gate_state_t;

   typedef struct packed {
      logic valid;
      logic is_uni;
   } gate_event_t;

   localparam int DEF_OPEN_TIMEOUT = 16;
   localparam int DEF_HOLDOFF      = 2;
   localparam int CNT_W            = 16;
   localparam int TOTAL_W          = 16;

endpackage

// File: rtl/parking_gate_lane.sv
// rtl/parking_gate_lane.sv - one barrier lane: vacancy check, open window with timeout, close and holdoff
module parking_gate_lane
   import parking_pkg::*;
#(
   parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
   parameter int HOLDOFF      = DEF_HOLDOFF,
   parameter bit CHECK_SPACE  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sensor,
   input  logic        sensor_is_uni,
   input  logic        pass,
   input  logic        uni_space,
   input  logic        gen_space,
   output logic        barrier_up,
   output logic        reject,
   output gate_event_t evt
);

   localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   gate_state_t       state_q, state_d;
   logic              cls_q, cls_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cls_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      cnt_d      = cnt_q;
      barrier_up = 1'b0;
      reject     = 1'b0;
      evt        = '0;
      case (state_q)
         ST_IDLE: begin
            if (sensor) begin
               state_d = ST_CHECK;
               cls_d   = sensor_is_uni;
            end
         end
         ST_CHECK: begin
            cnt_d = '0;
            // the exit lane never refuses a car
            if (!CHECK_SPACE || (cls_q ? uni_space : gen_space)) begin
               state_d = ST_OPEN;
            end else begin
               reject  = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_OPEN: begin
            barrier_up = 1'b1;
            if (pass) begin
               evt.valid  = 1'b1;
               evt.is_uni = cls_q;
               state_d    = ST_CLOSE;
            end else if (cnt_q == OPEN_LAST) begin
               state_d = ST_CLOSE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CLOSE: begin
            cnt_d   = '0;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt_q >= HOLD_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/parking_gate.sv
// rtl/parking_gate.sv - entry/exit lanes, event arbiter with one-deep exit deferral, and wrapping totals
module parking_gate
   import parking_pkg::*;
#(
   parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
   parameter int HOLDOFF      = DEF_HOLDOFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arrive,
   input  logic               arrive_is_uni,
   input  logic               entry_pass,
   input  logic               depart,
   input  logic               depart_is_uni,
   input  logic               exit_pass,
   input  logic               uni_is_vacated_space,
   input  logic               is_vacated_space,
   output logic               car_entered,
   output logic               is_uni_car_entered,
   output logic               car_exited,
   output logic               is_uni_car_exited,
   output logic               entry_barrier_up,
   output logic               exit_barrier_up,
   output logic               entry_reject,
   output logic [TOTAL_W-1:0] entered_total,
   output logic [TOTAL_W-1:0] exited_total
);

   gate_event_t ent_req, ext_req;
   logic        exit_reject_unused;

   parking_gate_lane #(
      .OPEN_TIMEOUT (OPEN_TIMEOUT),
      .HOLDOFF      (HOLDOFF),
      .CHECK_SPACE  (1'b1)
   ) u_entry (
      .clk           (clk),
      .rst           (rst),
      .sensor        (arrive),
      .sensor_is_uni (arrive_is_uni),
      .pass          (entry_pass),
      .uni_space     (uni_is_vacated_space),
      .gen_space     (is_vacated_space),
      .barrier_up    (entry_barrier_up),
      .reject        (entry_reject),
      .evt           (ent_req)
   );

   parking_gate_lane #(
      .OPEN_TIMEOUT (OPEN_TIMEOUT),
      .HOLDOFF      (HOLDOFF),
      .CHECK_SPACE  (1'b0)
   ) u_exit (
      .clk           (clk),
      .rst           (rst),
      .sensor        (depart),
      .sensor_is_uni (depart_is_uni),
      .pass          (exit_pass),
      .uni_space     (1'b1),
      .gen_space     (1'b1),
      .barrier_up    (exit_barrier_up),
      .reject        (exit_reject_unused),
      .evt           (ext_req)
   );

   gate_event_t        ent_evt_q, ent_evt_d;
   gate_event_t        ext_evt_q, ext_evt_d;
   gate_event_t        pend_q, pend_d;
   logic [TOTAL_W-1:0] entered_total_q, entered_total_d;
   logic [TOTAL_W-1:0] exited_total_q, exited_total_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_evt_q       <= '0;
         ext_evt_q       <= '0;
         pend_q          <= '0;
         entered_total_q <= '0;
         exited_total_q  <= '0;
      end else begin
         ent_evt_q       <= ent_evt_d;
         ext_evt_q       <= ext_evt_d;
         pend_q          <= pend_d;
         entered_total_q <= entered_total_d;
         exited_total_q  <= exited_total_d;
      end
   end

   // entry wins a collision; the exit is parked for one cycle in pend_q
   always_comb begin
      ent_evt_d = '0;
      ext_evt_d = '0;
      pend_d    = pend_q;
      if (ent_req.valid) begin
         ent_evt_d = ent_req;
         if (!pend_q.valid) begin
            pend_d = ext_req;
         end
      end else if (pend_q.valid) begin
         ext_evt_d = pend_q;
         pend_d    = ext_req;
      end else begin
         ext_evt_d = ext_req;
         pend_d    = '0;
      end
      entered_total_d = entered_total_q + TOTAL_W'(ent_evt_d.valid);
      exited_total_d  = exited_total_q + TOTAL_W'(ext_evt_d.valid);
   end

   assign car_entered        = ent_evt_q.valid;
   assign is_uni_car_entered = ent_evt_q.valid & ent_evt_q.is_uni;
   assign car_exited         = ext_evt_q.valid;
   assign is_uni_car_exited  = ext_evt_q.valid & ext_evt_q.is_uni;
   assign entered_total      = entered_total_q;
   assign exited_total       = exited_total_q;

endmodule
